// File: rtl/tt_checker.sv
// Self-checker for a 4-input combinational DUT: compares observed f1/f2 against
// truth tables over a 16-vector run, flags ordering errors and stalled streams.
module tt_checker #(
    parameter logic [15:0] EXP_F1  = 16'h6996,
    parameter logic [15:0] EXP_F2  = 16'h8000,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s_valid,
    input  logic [3:0] s_vec,
    input  logic       s_f1,
    input  logic       s_f2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_err_vec,
    output logic       order_err,
    output logic       timeout,
    output logic [1:0] dbg_state_o,
    output logic [3:0] dbg_exp_idx_o
);

    // Handshake: a sample transfers on a rising edge where state is RUN,
    // s_valid=1 and start=0; there is no back-pressure, so samples offered
    // outside RUN (or alongside start) are simply dropped.

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [4:0]    err_cnt_q, err_cnt_d;
    logic [3:0]    first_err_q, first_err_d;
    logic          order_err_q, order_err_d;
    logic          timeout_q, timeout_d;
    logic [3:0]    exp_idx_q, exp_idx_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    logic          mismatch;
    logic          out_of_order;

    // Look-up uses the vector actually applied, so a reordered stream is still
    // judged on its outputs.
    assign mismatch     = (s_f1 != EXP_F1[s_vec]) || (s_f2 != EXP_F2[s_vec]);
    assign out_of_order = (s_vec != exp_idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= 5'd0;
            first_err_q <= 4'd0;
            order_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            exp_idx_q   <= 4'd0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            order_err_q <= order_err_d;
            timeout_q   <= timeout_d;
            exp_idx_q   <= exp_idx_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        order_err_d = order_err_q;
        timeout_d   = timeout_q;
        exp_idx_d   = exp_idx_q;
        idle_cnt_d  = idle_cnt_q;

        if (start) begin
            state_d     = ST_RUN;
            pass_d      = 1'b0;
            err_cnt_d   = 5'd0;
            first_err_d = 4'd0;
            order_err_d = 1'b0;
            timeout_d   = 1'b0;
            exp_idx_d   = 4'd0;
            idle_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (s_valid) begin
                        idle_cnt_d = '0;
                        exp_idx_d  = exp_idx_q + 4'd1;
                        if (mismatch) begin
                            if (err_cnt_q != 5'd31) begin
                                err_cnt_d = err_cnt_q + 5'd1;
                            end
                            // err_cnt still zero means this is the run's first miss.
                            if (err_cnt_q == 5'd0) begin
                                first_err_d = s_vec;
                            end
                        end
                        if (out_of_order) begin
                            order_err_d = 1'b1;
                        end
                        if (exp_idx_q == 4'd15) begin
                            state_d = ST_DONE;
                            pass_d  = (err_cnt_d == 5'd0) && !order_err_d && !timeout_q;
                        end
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                        if (idle_cnt_d == TIMER_LIMIT) begin
                            state_d   = ST_DONE;
                            timeout_d = 1'b1;
                            pass_d    = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_vec = first_err_q;
    assign order_err     = order_err_q;
    assign timeout       = timeout_q;
    assign dbg_state_o   = state_q;
    assign dbg_exp_idx_o = exp_idx_q;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));
    a_pass_only_done: assert property (@(posedge clk) disable iff (!rst_n) pass_q |-> done_q);
    a_timer_bounded:  assert property (@(posedge clk) disable iff (!rst_n) idle_cnt_q <= TIMER_LIMIT);

endmodule

// File: tb/tb_tt_checker.sv
// Directed bench for tt_checker: table of full 16-vector runs plus hand-written
// sequences for timeout, mid-run reset, start/sample collision and DONE hold.
module tb_tt_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       s_valid;
  logic [3:0] s_vec;
  logic       s_f1;
  logic       s_f2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] first_err_vec;
  logic       order_err;
  logic       timeout;
  logic [1:0] dbg_state;
  logic [3:0] dbg_exp_idx;

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    string       name;
    logic [15:0] f1_flip;
    logic [15:0] f2_flip;
    bit          swap56;
    logic [4:0]  exp_err;
    logic [3:0]  exp_first;
    bit          exp_order;
    bit          exp_pass;
  } run_t;

  run_t tbl[4];

  tt_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .s_valid       (s_valid),
    .s_vec         (s_vec),
    .s_f1          (s_f1),
    .s_f2          (s_f2),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_vec (first_err_vec),
    .order_err     (order_err),
    .timeout       (timeout),
    .dbg_state_o   (dbg_state),
    .dbg_exp_idx_o (dbg_exp_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_pass"},  32'(pass), 32'd0);
    check({tag, "_err"},   32'(err_cnt), 32'd0);
    check({tag, "_first"}, 32'(first_err_vec), 32'd0);
    check({tag, "_order"}, 32'(order_err), 32'd0);
    check({tag, "_tmo"},   32'(timeout), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_idx"},   32'(dbg_exp_idx), 32'd0);
  endtask

  // drivers
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_err",  32'(err_cnt), 32'd0);
    check("start_idx",  32'(dbg_exp_idx), 32'd0);
  endtask

  task automatic send_sample(input logic [3:0] v, input logic f1, input logic f2);
    s_valid = 1'b1;
    s_vec   = v;
    s_f1    = f1;
    s_f2    = f2;
    tick();
    s_valid = 1'b0;
  endtask

  // Drives n samples 0..n-1 (optionally 5/6 swapped) with reference outputs
  // f1 = parity, f2 = AND, inverting where the flip masks say so; the
  // expected running error count is scoreboarded per sample.
  task automatic run_samples(input int n, input logic [15:0] f1_flip,
                             input logic [15:0] f2_flip, input bit swap56);
    logic [4:0] model_err;
    logic [3:0] v;
    logic       f1, f2;
    model_err = 5'd0;
    for (int i = 0; i < n; i++) begin
      v = 4'(i);
      if (swap56 && i == 5) v = 4'd6;
      else if (swap56 && i == 6) v = 4'd5;
      f1 = (^v) ^ f1_flip[i];
      f2 = (&v) ^ f2_flip[i];
      if (f1 != (^v) || f2 != (&v)) model_err = model_err + 5'd1;
      exp_q.push_back(model_err);
      send_sample(v, f1, f2);
      check($sformatf("err_cnt_s%0d", i), 32'(err_cnt), 32'(exp_q.pop_front()));
      check($sformatf("busy_s%0d", i), 32'(busy), (i < 15) ? 32'd1 : 32'd0);
      if (i != n - 1) repeat (19) tick();
    end
  endtask

  initial begin
    tbl[0] = '{"all_good",   16'h0000, 16'h0000,                 1'b0, 5'd0, 4'd0, 1'b0, 1'b1};
    tbl[1] = '{"f2_bad_3_9", 16'h0000, 16'h0208,                 1'b0, 5'd2, 4'd3, 1'b0, 1'b0};
    tbl[2] = '{"swap_5_6",   16'h0000, 16'h0000,                 1'b1, 5'd0, 4'd0, 1'b1, 1'b0};
    tbl[3] = '{"f1_bad_7_15", 16'h8080, 16'h0000,                1'b0, 5'd2, 4'd7, 1'b0, 1'b0};

    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_vec   = 4'd0;
    s_f1    = 1'b0;
    s_f2    = 1'b0;

    repeat (3) tick();
    check_idle_outputs("reset");
    #3 rst_n = 1'b1;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check_idle_outputs("post_reset");

    // table-driven full runs
    for (int t = 0; t < 4; t++) begin
      do_start();
      repeat (19) tick();
      run_samples(16, tbl[t].f1_flip, tbl[t].f2_flip, tbl[t].swap56);
      check({tbl[t].name, "_done"},  32'(done), 32'd1);
      check({tbl[t].name, "_pass"},  32'(pass), 32'(tbl[t].exp_pass));
      check({tbl[t].name, "_err"},   32'(err_cnt), 32'(tbl[t].exp_err));
      check({tbl[t].name, "_first"}, 32'(first_err_vec), 32'(tbl[t].exp_first));
      check({tbl[t].name, "_order"}, 32'(order_err), 32'(tbl[t].exp_order));
      check({tbl[t].name, "_tmo"},   32'(timeout), 32'd0);
      repeat (3) tick();
    end

    // timeout: 7 samples then silence; DONE exactly on the 64th idle edge
    do_start();
    run_samples(7, 16'h0000, 16'h0000, 1'b0);
    repeat (63) tick();
    check("tmo_not_yet_done", 32'(done), 32'd0);
    check("tmo_not_yet_busy", 32'(busy), 32'd1);
    tick();
    check("tmo_done",  32'(done), 32'd1);
    check("tmo_flag",  32'(timeout), 32'd1);
    check("tmo_pass",  32'(pass), 32'd0);
    check("tmo_busy",  32'(busy), 32'd0);
    check("tmo_idx",   32'(dbg_exp_idx), 32'd7);

    // asynchronous reset mid-run, checked before the next clock edge
    do_start();
    run_samples(8, 16'h0000, 16'h0010, 1'b0);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    #2 rst_n = 1'b1;
    tick();
    check("rst_release_state", 32'(dbg_state), 32'd0);
    do_start();
    run_samples(16, 16'h0000, 16'h0000, 1'b0);
    check("after_rst_done", 32'(done), 32'd1);
    check("after_rst_pass", 32'(pass), 32'd1);

    // start collides with a (bad) sample mid-run: restart wins, sample dropped
    do_start();
    run_samples(5, 16'h0000, 16'h0000, 1'b0);
    start   = 1'b1;
    s_valid = 1'b1;
    s_vec   = 4'd5;
    s_f1    = 1'b1;
    s_f2    = 1'b1;
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
    check("coll_busy",  32'(busy), 32'd1);
    check("coll_err",   32'(err_cnt), 32'd0);
    check("coll_idx",   32'(dbg_exp_idx), 32'd0);
    check("coll_order", 32'(order_err), 32'd0);
    run_samples(16, 16'h0000, 16'h0000, 1'b0);
    check("coll_done", 32'(done), 32'd1);
    check("coll_pass", 32'(pass), 32'd1);

    // samples offered in DONE must not disturb the held result
    s_valid = 1'b1;
    s_vec   = 4'd3;
    s_f1    = 1'b1;
    s_f2    = 1'b1;
    repeat (5) tick();
    s_valid = 1'b0;
    check("hold_done",  32'(done), 32'd1);
    check("hold_pass",  32'(pass), 32'd1);
    check("hold_err",   32'(err_cnt), 32'd0);
    check("hold_first", 32'(first_err_vec), 32'd0);
    check("hold_order", 32'(order_err), 32'd0);
    check("hold_idx",   32'(dbg_exp_idx), 32'd0);
    check("hold_busy",  32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
